// File: rtl/vga_scan_gen.sv
// Raster-scan timing source: pixel-enable divider, scan position counters,
// zero-skew registered sync/video decode and line/frame/game tick pulses.
module vga_scan_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int GAME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    output logic        pix_en,
    output logic [10:0] hor_reg,
    output logic [9:0]  ver_reg,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_tick,
    output logic        frame_tick,
    output logic        game_tick,
    output logic [7:0]  frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GDW     = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [GDW-1:0]   gdiv_q, gdiv_d;
    logic [10:0]      hor_q, hor_d;
    logic [9:0]       ver_q, ver_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             started_q, started_d;
    logic             pix_q, pix_d;
    logic             hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
    logic             lt_q, lt_d, ft_q, ft_d, gt_q, gt_d;

    always_comb begin
        pix_d     = (div_q == DIV_W'(CLK_DIV - 1));
        div_d     = pix_d ? '0 : div_q + 1'b1;
        started_d = started_q | pix_d;
        hor_d     = hor_q;
        ver_d     = ver_q;
        fcnt_d    = fcnt_q;
        gdiv_d    = gdiv_q;
        lt_d      = 1'b0;
        ft_d      = 1'b0;
        gt_d      = 1'b0;
        // The very first pixel only arms the scan at (0,0); stepping starts after it.
        if (pix_d && started_q) begin
            if (hor_q == 11'(H_TOTAL - 1)) begin
                hor_d = '0;
                lt_d  = 1'b1;
                if (ver_q == 10'(V_TOTAL - 1)) begin
                    ver_d  = '0;
                    ft_d   = 1'b1;
                    fcnt_d = fcnt_q + 8'd1;
                    if (!pause) begin
                        if (gdiv_q == GDW'(GAME_DIV - 1)) begin
                            gdiv_d = '0;
                            gt_d   = 1'b1;
                        end else begin
                            gdiv_d = gdiv_q + 1'b1;
                        end
                    end
                end else begin
                    ver_d = ver_q + 10'd1;
                end
            end else begin
                hor_d = hor_q + 11'd1;
            end
        end
        // Decode from next-state counters so the registered outputs line up with them.
        hs_d  = (started_d && hor_d >= 11'(H_ACTIVE + H_FP)
                 && hor_d < 11'(H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (started_d && ver_d >= 10'(V_ACTIVE + V_FP)
                 && ver_d < 10'(V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vid_d = started_d && (hor_d < 11'(H_ACTIVE)) && (ver_d < 10'(V_ACTIVE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            gdiv_q    <= '0;
            hor_q     <= '0;
            ver_q     <= '0;
            fcnt_q    <= '0;
            started_q <= 1'b0;
            pix_q     <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            vid_q     <= 1'b0;
            lt_q      <= 1'b0;
            ft_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            gdiv_q    <= gdiv_d;
            hor_q     <= hor_d;
            ver_q     <= ver_d;
            fcnt_q    <= fcnt_d;
            started_q <= started_d;
            pix_q     <= pix_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            vid_q     <= vid_d;
            lt_q      <= lt_d;
            ft_q      <= ft_d;
            gt_q      <= gt_d;
        end
    end

    assign pix_en     = pix_q;
    assign hor_reg    = hor_q;
    assign ver_reg    = ver_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign video_on   = vid_q;
    assign line_tick  = lt_q;
    assign frame_tick = ft_q;
    assign game_tick  = gt_q;
    assign frame_cnt  = fcnt_q;
endmodule
